// File: rtl/sr_trace_monitor.sv
// rtl/sr_trace_monitor.sv - execution-trace ring buffer with timeout/loop/watch stop triggers
module sr_trace_monitor #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 120,
    parameter int LOOP_CNT   = 4,
    parameter int POST_TRIG  = 2,
    parameter int WATCH_REG  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  valid,
    input  logic [31:0]           pc,
    input  logic [31:0]           instr,
    input  logic                  wb_we,
    input  logic [4:0]            wb_addr,
    input  logic [31:0]           wb_data,
    input  logic                  watch_en,
    input  logic [31:0]           watch_val,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [31:0]           rd_pc,
    output logic [31:0]           rd_instr,
    output logic [DEPTH_LOG2:0]   count,
    output logic [31:0]           cycles,
    output logic [1:0]            state,
    output logic [1:0]            cause,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = $clog2(LOOP_CNT + 1);
    localparam int PW    = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [31:0]           cycles_q, cycles_d;
    logic [1:0]            cause_q, cause_d;
    logic [LW-1:0]         loop_cnt_q, loop_cnt_d;
    logic [PW-1:0]         post_cnt_q, post_cnt_d;
    logic [31:0]           last_pc_q, last_pc_d;
    logic                  last_pc_vld_q, last_pc_vld_d;
    logic                  done_q, done_d;
    logic [31:0]           rd_pc_q, rd_pc_d;
    logic [31:0]           rd_instr_q, rd_instr_d;

    logic [31:0] mem_pc_q    [DEPTH];
    logic [31:0] mem_instr_q [DEPTH];

    logic                  wr_en;
    logic                  pc_match;
    logic                  trig_watch, trig_loop, trig_tmo;
    logic [DEPTH_LOG2-1:0] oldest, rd_slot;
    logic                  rd_hit;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        cycles_d      = cycles_q;
        cause_d       = cause_q;
        loop_cnt_d    = loop_cnt_q;
        post_cnt_d    = post_cnt_q;
        last_pc_d     = last_pc_q;
        last_pc_vld_d = last_pc_vld_q;
        wr_en         = 1'b0;

        trig_watch = watch_en && wb_we && (wb_addr == 5'(WATCH_REG)) &&
                     (wb_addr != 5'd0) && (wb_data == watch_val);
        pc_match   = last_pc_vld_q && (pc == last_pc_q);
        trig_loop  = valid && pc_match && (loop_cnt_q == LW'(LOOP_CNT - 1));
        trig_tmo   = (cycles_q == 32'(TIMEOUT - 1));

        if (arm) begin
            state_d       = S_RUN;
            wr_ptr_d      = '0;
            count_d       = '0;
            cycles_d      = '0;
            cause_d       = 2'd0;
            loop_cnt_d    = '0;
            last_pc_vld_d = 1'b0;
        end else if (state_q == S_RUN || state_q == S_POST) begin
            if (cycles_q != 32'hFFFF_FFFF)
                cycles_d = cycles_q + 32'd1;
            if (valid) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != FULL)
                    count_d = count_q + 1'b1;
            end
            if (state_q == S_RUN) begin
                if (valid) begin
                    loop_cnt_d    = pc_match ? loop_cnt_q + 1'b1 : '0;
                    last_pc_d     = pc;
                    last_pc_vld_d = 1'b1;
                end
                // Trigger priority: watch over loop over timeout
                if (trig_watch || trig_loop || trig_tmo) begin
                    cause_d = trig_watch ? 2'd3 : (trig_loop ? 2'd2 : 2'd1);
                    if (POST_TRIG == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_POST;
                        post_cnt_d = PW'(POST_TRIG);
                    end
                end
            end else begin
                post_cnt_d = post_cnt_q - 1'b1;
                if (post_cnt_q <= PW'(1))
                    state_d = S_DONE;
            end
        end

        done_d = (state_d == S_DONE);

        // Until the buffer wraps, slot 0 holds the oldest entry
        oldest     = (count_q != FULL) ? '0 : wr_ptr_q;
        rd_slot    = oldest + rd_idx;
        rd_hit     = ({1'b0, rd_idx} < count_q);
        rd_pc_d    = rd_hit ? mem_pc_q[rd_slot]    : 32'd0;
        rd_instr_d = rd_hit ? mem_instr_q[rd_slot] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            cycles_q      <= '0;
            cause_q       <= 2'd0;
            loop_cnt_q    <= '0;
            post_cnt_q    <= '0;
            last_pc_q     <= '0;
            last_pc_vld_q <= 1'b0;
            done_q        <= 1'b0;
            rd_pc_q       <= '0;
            rd_instr_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            cycles_q      <= cycles_d;
            cause_q       <= cause_d;
            loop_cnt_q    <= loop_cnt_d;
            post_cnt_q    <= post_cnt_d;
            last_pc_q     <= last_pc_d;
            last_pc_vld_q <= last_pc_vld_d;
            done_q        <= done_d;
            rd_pc_q       <= rd_pc_d;
            rd_instr_q    <= rd_instr_d;
        end
    end

    // Trace storage is left unreset; count hides stale contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc_q[wr_ptr_q]    <= pc;
            mem_instr_q[wr_ptr_q] <= instr;
        end
    end

    assign rd_pc    = rd_pc_q;
    assign rd_instr = rd_instr_q;
    assign count    = count_q;
    assign cycles   = cycles_q;
    assign state    = state_q;
    assign cause    = cause_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sr_trace_monitor.sv
// tb/tb_sr_trace_monitor.sv - bench for sr_trace_monitor: vector table, directed corners, random vs queue model
module tb_sr_trace_monitor;

    localparam int DEPTH     = 16;
    localparam int TIMEOUT   = 120;
    localparam int LOOP_CNT  = 4;
    localparam int POST_TRIG = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, valid, wb_we, watch_en;
    logic [31:0] pc, instr, wb_data, watch_val;
    logic [4:0]  wb_addr;
    logic [3:0]  rd_idx;
    logic [31:0] rd_pc, rd_instr, cycles;
    logic [4:0]  count;
    logic [1:0]  state, cause;
    logic        done;

    always #5 clk = ~clk;

    sr_trace_monitor dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .valid(valid), .pc(pc), .instr(instr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .watch_en(watch_en),
        .watch_val(watch_val), .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .count(count), .cycles(cycles), .state(state), .cause(cause), .done(done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] p);
        return p + 32'h0000_0013;
    endfunction

    // Reference model: trace is the list of the last DEPTH recorded entries, oldest first
    int          m_state;
    logic [1:0]  m_cause;
    logic [31:0] m_cycles;
    logic [31:0] m_pcs[$];
    logic [31:0] m_ins[$];
    bit          m_have_last;
    logic [31:0] m_last;
    int          m_run;
    int          m_post;
    logic [31:0] e_rd_pc, e_rd_in;

    task automatic model_reset();
        m_state = 0; m_cause = 2'd0; m_cycles = 32'd0;
        m_pcs.delete(); m_ins.delete();
        m_have_last = 0; m_last = 32'd0; m_run = 0; m_post = 0;
        e_rd_pc = 32'd0; e_rd_in = 32'd0;
    endtask

    task automatic model_step();
        bit tw, tl, tt;
        if (int'(rd_idx) < m_pcs.size()) begin
            e_rd_pc = m_pcs[rd_idx];
            e_rd_in = m_ins[rd_idx];
        end else begin
            e_rd_pc = 32'd0;
            e_rd_in = 32'd0;
        end
        if (arm) begin
            m_state = 1; m_cause = 2'd0; m_cycles = 32'd0;
            m_pcs.delete(); m_ins.delete();
            m_have_last = 0; m_run = 0;
            return;
        end
        if (m_state == 1 || m_state == 2) begin
            tt = (m_state == 1) && (m_cycles == 32'(TIMEOUT - 1));
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            tl = 0;
            if (valid) begin
                m_pcs.push_back(pc);
                m_ins.push_back(instr);
                if (m_pcs.size() > DEPTH) begin
                    void'(m_pcs.pop_front());
                    void'(m_ins.pop_front());
                end
                if (m_state == 1) begin
                    m_run = (m_have_last && pc == m_last) ? m_run + 1 : 1;
                    m_last = pc;
                    m_have_last = 1;
                    tl = (m_run == LOOP_CNT + 1);
                end
            end
            tw = (m_state == 1) && watch_en && wb_we && wb_addr == 5'd10 &&
                 wb_addr != 5'd0 && wb_data == watch_val;
            if (m_state == 1) begin
                if (tw || tl || tt) begin
                    m_cause = tw ? 2'd3 : (tl ? 2'd2 : 2'd1);
                    m_state = (POST_TRIG == 0) ? 3 : 2;
                    m_post  = POST_TRIG;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state",    32'(state),    32'(m_state));
        chk("cause",    32'(cause),    32'(m_cause));
        chk("done",     32'(done),     32'(m_state == 3));
        chk("count",    32'(count),    32'(m_pcs.size()));
        chk("cycles",   cycles,        m_cycles);
        chk("rd_pc",    rd_pc,         e_rd_pc);
        chk("rd_instr", rd_instr,      e_rd_in);
    endtask

    task automatic idle_inputs();
        arm = 0; valid = 0; pc = 0; instr = 0; wb_we = 0; wb_addr = 0; wb_data = 0; rd_idx = 0;
    endtask

    task automatic rec(input logic [31:0] p);
        valid = 1; pc = p; instr = ins(p);
        tick();
        valid = 0;
    endtask

    task automatic do_arm();
        arm = 1;
        tick();
        arm = 0;
    endtask

    typedef struct {
        logic        arm;
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  rd_idx;
        logic [1:0]  e_state;
        logic [4:0]  e_count;
        logic [31:0] e_cycles;
        logic [31:0] e_rd_pc;
        logic [31:0] e_rd_instr;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic v, input logic [31:0] p, input logic [3:0] r,
                                input logic [1:0] s, input logic [4:0] c, input logic [31:0] cy,
                                input logic [31:0] rp, input logic [31:0] ri);
        vec_t x;
        x.arm = a; x.valid = v; x.pc = p; x.rd_idx = r;
        x.e_state = s; x.e_count = c; x.e_cycles = cy; x.e_rd_pc = rp; x.e_rd_instr = ri;
        return x;
    endfunction

    vec_t tbl[8];

    initial begin
        tbl[0] = mk(1, 0, 32'h00, 4'd0, 2'd1, 5'd0, 32'd0, 32'h00, 32'h00);
        tbl[1] = mk(0, 1, 32'h00, 4'd0, 2'd1, 5'd1, 32'd1, 32'h00, 32'h00);
        tbl[2] = mk(0, 1, 32'h04, 4'd0, 2'd1, 5'd2, 32'd2, 32'h00, 32'h13);
        tbl[3] = mk(0, 1, 32'h08, 4'd1, 2'd1, 5'd3, 32'd3, 32'h04, 32'h17);
        tbl[4] = mk(0, 0, 32'h00, 4'd0, 2'd1, 5'd3, 32'd4, 32'h00, 32'h13);
        tbl[5] = mk(0, 0, 32'h00, 4'd1, 2'd1, 5'd3, 32'd5, 32'h04, 32'h17);
        tbl[6] = mk(0, 0, 32'h00, 4'd2, 2'd1, 5'd3, 32'd6, 32'h08, 32'h1b);
        tbl[7] = mk(0, 0, 32'h00, 4'd3, 2'd1, 5'd3, 32'd7, 32'h00, 32'h00);

        rst_n = 0; watch_en = 0; watch_val = 32'd55;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst state",  32'(state), 32'd0);
        chk("rst count",  32'(count), 32'd0);
        chk("rst cycles", cycles,     32'd0);
        chk("rst cause",  32'(cause), 32'd0);
        chk("rst done",   32'(done),  32'd0);
        chk("rst rd_pc",  rd_pc,      32'd0);
        rst_n = 1;

        // Basic record and readout
        for (int i = 0; i < 8; i++) begin
            arm = tbl[i].arm; valid = tbl[i].valid; pc = tbl[i].pc;
            instr = ins(tbl[i].pc); rd_idx = tbl[i].rd_idx;
            tick();
            chk($sformatf("tbl%0d state", i),  32'(state), 32'(tbl[i].e_state));
            chk($sformatf("tbl%0d count", i),  32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d cycles", i), cycles,     tbl[i].e_cycles);
            chk($sformatf("tbl%0d rd_pc", i),  rd_pc,      tbl[i].e_rd_pc);
            chk($sformatf("tbl%0d rd_in", i),  rd_instr,   tbl[i].e_rd_instr);
        end
        idle_inputs();

        // Wrap
        do_arm();
        for (int i = 0; i < 20; i++) rec(32'(4 * i));
        rd_idx = 4'd0;  tick(); chk("wrap oldest", rd_pc, 32'h10);
        rd_idx = 4'd15; tick(); chk("wrap newest", rd_pc, 32'h4C);
        chk("wrap count", 32'(count), 32'd16);
        chk("wrap cause", 32'(cause), 32'd0);
        chk("wrap state", 32'(state), 32'd1);
        rd_idx = 0;

        // Halt loop
        do_arm();
        rec(32'h00); rec(32'h04);
        for (int i = 0; i < 4; i++) rec(32'h08);
        chk("loop pre cause", 32'(cause), 32'd0);
        rec(32'h08);
        chk("loop cause", 32'(cause), 32'd2);
        chk("loop post0", 32'(state), 32'd2);
        rd_idx = 4'd6; tick();
        chk("loop post1", 32'(state), 32'd2);
        chk("loop newest", rd_pc, 32'h08);
        tick();
        chk("loop done st", 32'(state), 32'd3);
        chk("loop done", 32'(done), 32'd1);
        rd_idx = 0;

        // Timeout
        do_arm();
        for (int k = 1; k <= 125; k++) begin
            tick();
            if (k == 119) chk("tmo early cause", 32'(cause), 32'd0);
            if (k == 120) begin
                chk("tmo cause", 32'(cause), 32'd1);
                chk("tmo post",  32'(state), 32'd2);
            end
            if (k == 122) begin
                chk("tmo done",   32'(done),  32'd1);
                chk("tmo cycles", cycles,     32'd122);
                chk("tmo count",  32'(count), 32'd0);
            end
            if (k == 125) chk("tmo frozen", cycles, 32'd122);
        end

        // Watch: x0 ignored, x10 wins over simultaneous timeout
        watch_en = 1; watch_val = 32'd55;
        do_arm();
        wb_we = 1; wb_addr = 5'd0; wb_data = 32'd55;
        tick();
        chk("watch x0 cause", 32'(cause), 32'd0);
        chk("watch x0 state", 32'(state), 32'd1);
        wb_we = 0;
        for (int k = 0; k < 118; k++) tick();
        chk("watch pre cycles", cycles, 32'd119);
        wb_we = 1; wb_addr = 5'd10; wb_data = 32'd55;
        tick();
        chk("watch cause", 32'(cause), 32'd3);
        wb_we = 0;
        repeat (3) tick();

        // Re-arm mid-RUN, then reset mid-POST
        do_arm();
        rec(32'h40); rec(32'h44); rec(32'h48);
        arm = 1; valid = 1; pc = 32'h4C; instr = ins(32'h4C);
        tick();
        arm = 0; valid = 0;
        chk("rearm count",  32'(count), 32'd0);
        chk("rearm cycles", cycles,     32'd0);
        chk("rearm cause",  32'(cause), 32'd0);
        rec(32'h100);
        rd_idx = 0; tick();
        wb_we = 1; wb_addr = 5'd10; wb_data = 32'd55;
        tick();
        wb_we = 0;
        chk("pre-rst state", 32'(state), 32'd2);
        chk("pre-rst rd_pc", rd_pc, 32'h100);
        #1 rst_n = 0;
        #1;
        chk("arst state", 32'(state), 32'd0);
        chk("arst done",  32'(done),  32'd0);
        chk("arst rd_pc", rd_pc,      32'd0);
        chk("arst count", 32'(count), 32'd0);
        model_reset();
        @(posedge clk); #1 rst_n = 1;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            arm   = (n == 0) || ($urandom_range(0, 39) == 0);
            valid = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 1) == 0) pc = 32'($urandom_range(0, 7) * 4);
            instr    = $urandom;
            wb_we    = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       wb_addr = 5'd0;
                1:       wb_addr = 5'd10;
                default: wb_addr = 5'($urandom);
            endcase
            wb_data  = ($urandom_range(0, 3) == 0) ? watch_val : $urandom;
            watch_en = $urandom_range(0, 1);
            rd_idx   = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
